// File: rtl/pipeline_if_stage1_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//   imem_req    : request valid (fetch -> mem), held with imem_addr until imem_gnt
//   imem_addr   : 64-bit word-aligned fetch address
//   imem_gnt    : memory accepted the request this cycle
//   imem_rvalid : response data valid
//   imem_rdata  : 32-bit instruction word
// Modports: master = fetch stage, slave = memory.
interface pipeline_if_stage1_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/pipeline_if_stage1.sv
// Instruction fetch stage 1: issues one outstanding imem request at a time,
// presents the fetched instruction and its PC to the decode-control stage,
// absorbs downstream stalls with a one-entry buffer and handles redirects.
//
// Ports:
//   clk            : clock, all state updates on rising edge
//   reset          : asynchronous active-high reset
//   stall          : decode-control not accepting; outputs hold
//   redirect       : jump/branch/flush redirect request (highest priority)
//   redirect_pc    : new fetch address, bits [1:0] ignored
//   imem           : instruction memory bus (master side)
//   instruction_IF : fetched instruction (NOP_INST when no instruction)
//   pc_IFR         : PC of instruction_IF
//   valid_IF       : instruction_IF/pc_IFR hold a real instruction
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_REQ  | request driven on imem (imem_req=1, imem_addr=fetch_pc)
// ST_WAIT | request granted, awaiting imem_rvalid
// ST_HOLD | instruction captured while stalled, no request in flight
module pipeline_if_stage1 #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        redirect,
  input  logic [63:0]                 redirect_pc,
  pipeline_if_stage1_if.master        imem,
  output logic [31:0]                 instruction_IF,
  output logic [63:0]                 pc_IFR,
  output logic                        valid_IF
);

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD} state_t;

  state_t      state;
  logic [63:0] fetch_pc;
  logic [63:0] addr_q;
  logic        req_q;
  logic        discard;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [63:0] buf_pc;

  logic [63:0] redirect_addr;
  logic [63:0] pc_inc;
  logic        gnt_hit;

  assign redirect_addr  = {redirect_pc[63:2], 2'b00};
  assign pc_inc         = fetch_pc + 64'd4;
  // gnt only counts while a request is actually on the bus (not the idle
  // cycle straight out of reset).
  assign gnt_hit        = req_q & imem.imem_gnt;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_REQ;
      fetch_pc       <= RESET_PC;
      addr_q         <= RESET_PC;
      req_q          <= 1'b0;
      discard        <= 1'b0;
      buf_valid      <= 1'b0;
      buf_inst       <= NOP_INST;
      buf_pc         <= '0;
      instruction_IF <= NOP_INST;
      pc_IFR         <= '0;
      valid_IF       <= 1'b0;
    end else if (redirect) begin
      fetch_pc       <= redirect_addr;
      instruction_IF <= NOP_INST;
      valid_IF       <= 1'b0;
      buf_valid      <= 1'b0;
      if ((state == ST_WAIT && !imem.imem_rvalid) || (state == ST_REQ && gnt_hit)) begin
        // A request is in flight; its response must be dropped on arrival.
        state   <= ST_WAIT;
        req_q   <= 1'b0;
        discard <= 1'b1;
      end else begin
        // Nothing in flight (or the stale response lands right now and is
        // simply not captured). Refetch waits for stall to drop.
        discard <= 1'b0;
        if (stall) begin
          state <= ST_HOLD;
          req_q <= 1'b0;
        end else begin
          state  <= ST_REQ;
          req_q  <= 1'b1;
          addr_q <= redirect_addr;
        end
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (gnt_hit) begin
            state <= ST_WAIT;
            req_q <= 1'b0;
          end else begin
            req_q <= 1'b1;
          end
          if (!stall) begin
            instruction_IF <= NOP_INST;
            valid_IF       <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (imem.imem_rvalid && discard) begin
            discard <= 1'b0;
            state   <= ST_REQ;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc;
            if (!stall) begin
              instruction_IF <= NOP_INST;
              valid_IF       <= 1'b0;
            end
          end else if (imem.imem_rvalid) begin
            fetch_pc <= pc_inc;
            if (!stall) begin
              instruction_IF <= imem.imem_rdata;
              pc_IFR         <= fetch_pc;
              valid_IF       <= 1'b1;
              state          <= ST_REQ;
              req_q          <= 1'b1;
              addr_q         <= pc_inc;
            end else begin
              state <= ST_HOLD;
              if (!valid_IF) begin
                // Outputs hold nothing real, so they can take it directly.
                instruction_IF <= imem.imem_rdata;
                pc_IFR         <= fetch_pc;
                valid_IF       <= 1'b1;
              end else begin
                buf_valid <= 1'b1;
                buf_inst  <= imem.imem_rdata;
                buf_pc    <= fetch_pc;
              end
            end
          end else if (!stall) begin
            instruction_IF <= NOP_INST;
            valid_IF       <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (!stall) begin
            state  <= ST_REQ;
            req_q  <= 1'b1;
            addr_q <= fetch_pc;
            if (buf_valid) begin
              instruction_IF <= buf_inst;
              pc_IFR         <= buf_pc;
              valid_IF       <= 1'b1;
              buf_valid      <= 1'b0;
            end else begin
              instruction_IF <= NOP_INST;
              valid_IF       <= 1'b0;
            end
          end
        end

        default: begin
          state <= ST_REQ;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_if_stage1.sv
module tb_pipeline_if_stage1;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instruction_IF;
  logic [63:0] pc_IFR;
  logic        valid_IF;

  pipeline_if_stage1_if imem();

  pipeline_if_stage1 #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem(imem),
    .instruction_IF(instruction_IF),
    .pc_IFR(pc_IFR),
    .valid_IF(valid_IF)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          tests_run;
  int          tests_failed;
  logic        mem_auto;
  logic        resp_pending;
  logic [63:0] resp_addr;
  logic        prev_valid;
  logic [63:0] prev_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] inst_for(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 32'h0050_0093;
    return {a[31:2], 2'b11} ^ 32'h1234_5600;
  endfunction

  task automatic push_exp(input logic [63:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = inst_for(pc);
    sb.push_back(e);
  endtask

  // Memory model: grants any request immediately, responds the next cycle.
  task automatic mem_drive();
    imem.imem_rvalid = resp_pending;
    if (resp_pending) imem.imem_rdata = inst_for(resp_addr);
    resp_pending = 1'b0;
    imem.imem_gnt = imem.imem_req;
    if (imem.imem_req) begin
      resp_pending = 1'b1;
      resp_addr    = imem.imem_addr;
    end
  endtask

  task automatic mem_idle();
    mem_auto         = 1'b0;
    resp_pending     = 1'b0;
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b0;
  endtask

  // Every new instruction presented on the outputs is popped from the scoreboard.
  task automatic monitor();
    exp_t e;
    if (valid_IF && (!prev_valid || pc_IFR != prev_pc)) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_output: got pc=%h inst=%h, none expected", pc_IFR, instruction_IF);
      end else begin
        e = sb.pop_front();
        if (pc_IFR !== e.pc || instruction_IF !== e.inst) begin
          tests_failed++;
          $display("FAIL sb_output: got pc=%h inst=%h, exp pc=%h inst=%h",
                   pc_IFR, instruction_IF, e.pc, e.inst);
        end
      end
    end
    prev_valid = valid_IF;
    prev_pc    = pc_IFR;
  endtask

  task automatic tick();
    @(negedge clk);
    if (mem_auto) mem_drive();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic drain(input int budget, output int used, output int vcount);
    used   = 0;
    vcount = 0;
    while (sb.size() != 0 && used < budget) begin
      tick();
      used++;
      if (valid_IF) vcount++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d expected outputs not seen in %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests_run += 4;
    if (imem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b exp 0", imem.imem_req); end
    if (valid_IF !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", valid_IF); end
    if (instruction_IF !== NOP_INST) begin tests_failed++; $display("FAIL reset_inst: got %h exp %h", instruction_IF, NOP_INST); end
    if (pc_IFR !== 64'd0) begin tests_failed++; $display("FAIL reset_pc: got %h exp 0", pc_IFR); end
    reset = 1'b0;
    tick();
    tests_run += 2;
    if (imem.imem_req !== 1'b1) begin tests_failed++; $display("FAIL first_req: got %b exp 1", imem.imem_req); end
    if (imem.imem_addr !== RESET_PC) begin tests_failed++; $display("FAIL first_addr: got %h exp %h", imem.imem_addr, RESET_PC); end
    imem.imem_gnt = 1'b1;
    tick();
    tests_run++;
    if (imem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL req_after_gnt: got %b exp 0", imem.imem_req); end
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 32'h0050_0093;
    push_exp(RESET_PC);
    tick();
    imem.imem_rvalid = 1'b0;
    tests_run += 4;
    if (valid_IF !== 1'b1) begin tests_failed++; $display("FAIL first_valid: got %b exp 1", valid_IF); end
    if (instruction_IF !== 32'h0050_0093) begin tests_failed++; $display("FAIL first_inst: got %h exp 00500093", instruction_IF); end
    if (imem.imem_req !== 1'b1) begin tests_failed++; $display("FAIL next_req: got %b exp 1", imem.imem_req); end
    if (imem.imem_addr !== 64'h8000_0004) begin tests_failed++; $display("FAIL next_addr: got %h exp 80000004", imem.imem_addr); end
  endtask

  task automatic test_stall();
    int used, vc;
    mem_auto = 1'b1;
    push_exp(64'h8000_0004);
    drain(6, used, vc);
    stall = 1'b1;
    push_exp(64'h8000_0008);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (pc_IFR !== 64'h8000_0004 || instruction_IF !== inst_for(64'h8000_0004) || valid_IF !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got pc=%h inst=%h v=%b exp pc=80000004 v=1", i, pc_IFR, instruction_IF, valid_IF);
      end
    end
    tests_run++;
    if (sb.size() != 1) begin tests_failed++; $display("FAIL stall_buffered: got %0d pending exp 1", sb.size()); end
    stall = 1'b0;
    tick();
    tests_run += 3;
    if (pc_IFR !== 64'h8000_0008 || valid_IF !== 1'b1) begin tests_failed++; $display("FAIL buf_present: got pc=%h v=%b exp pc=80000008 v=1", pc_IFR, valid_IF); end
    if (sb.size() != 0) begin tests_failed++; $display("FAIL buf_popped: got %0d pending exp 0", sb.size()); end
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'h8000_000C) begin tests_failed++; $display("FAIL after_stall_addr: got req=%b addr=%h exp 1/8000000c", imem.imem_req, imem.imem_addr); end
  endtask

  task automatic test_stream();
    int used, vc;
    for (int i = 0; i < 4; i++) push_exp(64'h8000_000C + 64'(4 * i));
    drain(20, used, vc);
    tests_run += 2;
    if (used != 8) begin tests_failed++; $display("FAIL stream_cycles: got %0d exp 8", used); end
    if (vc != 4) begin tests_failed++; $display("FAIL stream_valid_cycles: got %0d exp 4", vc); end
    mem_idle();
  endtask

  task automatic test_redirect_wait();
    int used, vc;
    stall = 1'b1;
    imem.imem_gnt = 1'b1;
    tick();
    imem.imem_gnt = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_1003;
    tick();
    redirect = 1'b0;
    tests_run += 3;
    if (valid_IF !== 1'b0) begin tests_failed++; $display("FAIL rdw_valid: got %b exp 0", valid_IF); end
    if (instruction_IF !== NOP_INST) begin tests_failed++; $display("FAIL rdw_inst: got %h exp %h", instruction_IF, NOP_INST); end
    if (imem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rdw_req_wait: got %b exp 0", imem.imem_req); end
    tick();
    tests_run++;
    if (imem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rdw_still_wait: got %b exp 0", imem.imem_req); end
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem.imem_rvalid = 1'b0;
    tests_run += 3;
    if (valid_IF !== 1'b0) begin tests_failed++; $display("FAIL rdw_drop_valid: got %b exp 0", valid_IF); end
    if (instruction_IF !== NOP_INST) begin tests_failed++; $display("FAIL rdw_drop_inst: got %h exp %h", instruction_IF, NOP_INST); end
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'h8000_1000) begin tests_failed++; $display("FAIL rdw_new_addr: got req=%b addr=%h exp 1/80001000", imem.imem_req, imem.imem_addr); end
    mem_auto = 1'b1;
    push_exp(64'h8000_1000);
    drain(6, used, vc);
    mem_idle();
  endtask

  task automatic test_redirect_stall();
    int used, vc;
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_2000;
    tick();
    redirect = 1'b0;
    tests_run += 2;
    if (valid_IF !== 1'b0) begin tests_failed++; $display("FAIL rds_valid: got %b exp 0", valid_IF); end
    if (instruction_IF !== NOP_INST) begin tests_failed++; $display("FAIL rds_inst: got %h exp %h", instruction_IF, NOP_INST); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (imem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rds_no_fetch[%0d]: got %b exp 0", i, imem.imem_req); end
    end
    stall = 1'b0;
    tick();
    tests_run++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'h8000_2000) begin tests_failed++; $display("FAIL rds_resume: got req=%b addr=%h exp 1/80002000", imem.imem_req, imem.imem_addr); end
    mem_auto = 1'b1;
    push_exp(64'h8000_2000);
    drain(6, used, vc);
    mem_idle();
  endtask

  task automatic test_wrap();
    int used, vc;
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect = 1'b0;
    tests_run++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin tests_failed++; $display("FAIL wrap_align: got req=%b addr=%h exp 1/fffffffffffffffc", imem.imem_req, imem.imem_addr); end
    mem_auto = 1'b1;
    push_exp(64'hFFFF_FFFF_FFFF_FFFC);
    drain(6, used, vc);
    mem_idle();
    tests_run++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'd0) begin tests_failed++; $display("FAIL wrap_next: got req=%b addr=%h exp 1/0", imem.imem_req, imem.imem_addr); end
  endtask

  task automatic test_reset_mid();
    int used, vc;
    imem.imem_gnt = 1'b1;
    tick();
    imem.imem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    tests_run += 2;
    if (imem.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rmid_req: got %b exp 0", imem.imem_req); end
    if (pc_IFR !== 64'd0) begin tests_failed++; $display("FAIL rmid_pc: got %h exp 0", pc_IFR); end
    tick();
    reset            = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 32'hBAD0_0BAD;
    tick();
    tests_run += 2;
    if (valid_IF !== 1'b0) begin tests_failed++; $display("FAIL rmid_stale1: got %b exp 0", valid_IF); end
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== RESET_PC) begin tests_failed++; $display("FAIL rmid_restart: got req=%b addr=%h exp 1/%h", imem.imem_req, imem.imem_addr, RESET_PC); end
    tick();
    imem.imem_rvalid = 1'b0;
    tests_run++;
    if (valid_IF !== 1'b0) begin tests_failed++; $display("FAIL rmid_stale2: got %b exp 0", valid_IF); end
    mem_auto = 1'b1;
    push_exp(RESET_PC);
    drain(6, used, vc);
    mem_idle();
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    prev_valid       = 1'b0;
    prev_pc          = '0;
    resp_pending     = 1'b0;
    resp_addr        = '0;
    mem_auto         = 1'b0;
    reset            = 1'b1;
    stall            = 1'b0;
    redirect         = 1'b0;
    redirect_pc      = '0;
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = '0;

    test_reset();
    test_stall();
    test_stream();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_if_stage1.md
PIPELINE_IF_STAGE1 -- requirements
Module: pipeline_if_stage1

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013: bubble instruction (addi x0,x0,0).
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  downstream decode-control stage not accepting; hold outputs.
REQ-007 redirect  input  1  jump/branch/flush redirect request.
REQ-008 redirect_pc  input  64  new fetch address, valid with redirect.
REQ-009 imem_req  output  1  instruction memory request valid.
REQ-010 imem_addr  output  64  request address, word aligned.
REQ-011 imem_gnt  input  1  memory accepted request this cycle.
REQ-012 imem_rvalid  input  1  response data valid.
REQ-013 imem_rdata  input  32  response instruction.
REQ-014 instruction_IF  output  32  fetched instruction to decode-control stage.
REQ-015 pc_IFR  output  64  PC of instruction_IF.
REQ-016 valid_IF  output  1  instruction_IF/pc_IFR hold a real instruction.

Function
REQ-017 SHALL keep at most one outstanding memory request.
REQ-018 SHALL use FSM states REQ (imem_req=1), WAIT (request granted, awaiting rvalid), HOLD (instruction captured, stall asserted).
REQ-019 REQ: imem_req=1, imem_addr=fetch_pc; on imem_gnt go WAIT; imem_addr and imem_req SHALL stay stable until gnt.
REQ-020 WAIT: on imem_rvalid capture imem_rdata and fetch_pc into outputs, valid_IF=1, fetch_pc+=4 (64-bit wrap modulo 2^64); next state REQ if stall=0, else HOLD.
REQ-021 HOLD: outputs frozen; when stall deasserts go REQ; valid_IF cleared in the same edge unless a new response lands.
REQ-022 When no instruction is captured on an edge and stall=0, SHALL drive instruction_IF=NOP_INST, valid_IF=0, pc_IFR unchanged.
REQ-023 While stall=1, SHALL not change instruction_IF, pc_IFR, valid_IF (except redirect, REQ-024); a response arriving under stall SHALL be captured only if valid_IF=0, else held in a one-entry buffer and presented when stall drops.
REQ-024 redirect SHALL have priority over stall and all FSM activity: next edge fetch_pc=redirect_pc, instruction_IF=NOP_INST, valid_IF=0, buffer cleared.
REQ-025 redirect in WAIT: SHALL set a discard flag; the pending response is dropped on arrival; new request issued next cycle after drop (REQ state entered then).
REQ-026 redirect in REQ without gnt same cycle: request withdrawn, next cycle imem_addr=redirect_pc; with gnt same cycle: treated as WAIT with discard.
REQ-027 redirect_pc[1:0] SHALL be ignored (forced to 0).
REQ-028 Fetch-to-output latency SHALL be 1 cycle after imem_rvalid; minimum throughput one instruction per 2 cycles with single-cycle memory.

Reset
REQ-029 During reset: fetch_pc=RESET_PC, state=REQ, imem_req=0, instruction_IF=NOP_INST, pc_IFR=0, valid_IF=0, discard flag and buffer cleared.
REQ-030 First edge after reset release SHALL assert imem_req with imem_addr=RESET_PC.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding request; any later rvalid before the first new gnt SHALL be ignored.

Verification
REQ-032 Reset release, memory gnt immediate, rvalid next cycle with 32'h00500093 -> instruction_IF=32'h00500093, pc_IFR=0x80000000, valid_IF=1; next imem_addr=0x80000004.
REQ-033 stall=1 for 3 cycles after capture at 0x80000004 -> outputs unchanged 3 cycles; second response buffered and appears with pc_IFR=0x80000008 the edge after stall drops.
REQ-034 redirect=1, redirect_pc=0x80001003 while in WAIT -> pending rdata discarded, valid_IF=0, instruction_IF=0x00000013, next imem_addr=0x80001000.
REQ-035 redirect and stall asserted together -> redirect wins, valid_IF=0, fetch resumes at redirect_pc once stall drops.
REQ-036 fetch_pc=0xFFFFFFFFFFFFFFFC fetched -> next imem_addr=0x0000000000000000.
REQ-037 reset pulse during WAIT, stale rvalid arrives after release -> ignored, first captured pc_IFR=RESET_PC.
